// File: rtl/dm_pkg.sv
// Shared debug-module types: DTM op/status encodings, DMI channel structs and
// the TCK-side access-controller state encoding.
package dm;

    typedef enum logic [1:0] {
        DTM_NOP      = 2'd0,
        DTM_READ     = 2'd1,
        DTM_WRITE    = 2'd2,
        DTM_RESERVED = 2'd3
    } dtm_op_e;

    typedef enum logic [1:0] {
        DTM_SUCCESS      = 2'd0,
        DTM_ERR_RESERVED = 2'd1,
        DTM_ERR          = 2'd2,
        DTM_BUSY         = 2'd3
    } dtm_op_status_e;

    localparam int unsigned DmiAddrW = 7;
    localparam int unsigned DmiDataW = 32;

    typedef struct packed {
        logic [DmiAddrW-1:0] addr;
        dtm_op_e             op;
        logic [DmiDataW-1:0] data;
    } dmi_req_t;

    typedef struct packed {
        logic [DmiDataW-1:0] data;
        logic [1:0]          resp;
    } dmi_resp_t;

    typedef enum logic [2:0] {
        Idle,
        Read,
        WaitRead,
        Write,
        WaitWrite
    } state_e;

endpackage

// File: rtl/dmi_jtag_access_ctrl.sv
// TCK-domain DMI access controller: owns the DMI data register, issues one
// DMI read/write per Update-DR and keeps the sticky dmistat error.
module dmi_jtag_access_ctrl
    import dm::*;
#(
    parameter int unsigned AddrWidth = 7,
    parameter int unsigned DataWidth = 32
) (
    input  logic                 tck_i,
    input  logic                 trst_ni,
    input  logic                 dmi_access_i,
    input  logic                 capture_dr_i,
    input  logic                 shift_dr_i,
    input  logic                 update_dr_i,
    input  logic                 test_logic_reset_i,
    input  logic                 dmi_reset_i,
    input  logic                 dmi_tdi_i,
    output logic                 dmi_tdo_o,
    output logic [1:0]           dmi_error_o,
    output logic                 dmi_req_valid_o,
    input  logic                 dmi_req_ready_i,
    output logic [AddrWidth-1:0] dmi_req_addr_o,
    output logic [1:0]           dmi_req_op_o,
    output logic [DataWidth-1:0] dmi_req_data_o,
    input  logic                 dmi_resp_valid_i,
    output logic                 dmi_resp_ready_o,
    input  logic [DataWidth-1:0] dmi_resp_data_i,
    input  logic [1:0]           dmi_resp_resp_i
);

    localparam int unsigned DrWidth = AddrWidth + DataWidth + 2;

    state_e               r_state;
    state_e               w_state_next;
    logic [DrWidth-1:0]   r_dr;
    logic [AddrWidth-1:0] r_addr;
    logic [DataWidth-1:0] r_data;
    dtm_op_e              r_op;
    logic [1:0]           r_error;

    dtm_op_e w_dr_op;
    logic    w_busy;
    logic    w_dr_op_valid;
    logic    w_start;
    logic    w_busy_hit;
    logic    w_resp_fire;
    logic    w_resp_fail;

    assign w_dr_op       = dtm_op_e'(r_dr[1:0]);
    assign w_busy        = (r_state != Idle);
    assign w_dr_op_valid = (w_dr_op == DTM_READ) || (w_dr_op == DTM_WRITE);
    assign w_start       = dmi_access_i && update_dr_i && !w_busy
                           && (r_error == 2'd0) && w_dr_op_valid;
    // Touching the DR while a transaction is in flight is what the host sees as busy.
    assign w_busy_hit    = dmi_access_i && (capture_dr_i || update_dr_i) && w_busy;
    assign w_resp_fire   = dmi_resp_valid_i && ((r_state == WaitRead) || (r_state == WaitWrite));
    assign w_resp_fail   = w_resp_fire && (dmi_resp_resp_i != 2'd0);

    always_ff @(posedge tck_i) begin
        if (!trst_ni) begin
            r_state <= Idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        dmi_req_valid_o  = 1'b0;
        dmi_resp_ready_o = 1'b0;
        case (r_state)
            Idle: begin
                if (w_start) begin
                    if (w_dr_op == DTM_READ) begin
                        w_state_next = Read;
                    end else begin
                        w_state_next = Write;
                    end
                end
            end
            Read: begin
                dmi_req_valid_o = 1'b1;
                if (dmi_req_ready_i) w_state_next = WaitRead;
            end
            Write: begin
                dmi_req_valid_o = 1'b1;
                if (dmi_req_ready_i) w_state_next = WaitWrite;
            end
            WaitRead, WaitWrite: begin
                dmi_resp_ready_o = 1'b1;
                if (dmi_resp_valid_i) w_state_next = Idle;
            end
            default: w_state_next = Idle;
        endcase
    end

    always_ff @(posedge tck_i) begin
        if (!trst_ni) begin
            r_dr <= '0;
        end else if (test_logic_reset_i) begin
            r_dr <= '0;
        end else if (dmi_access_i) begin
            if (capture_dr_i) begin
                r_dr <= {r_addr, r_data, (w_busy ? 2'b11 : r_error)};
            end else if (shift_dr_i) begin
                r_dr <= {dmi_tdi_i, r_dr[DrWidth-1:1]};
            end
        end
    end

    // Read data lands even during Test-Logic-Reset so an in-flight read still completes.
    always_ff @(posedge tck_i) begin
        if (!trst_ni) begin
            r_addr <= '0;
            r_data <= '0;
            r_op   <= DTM_NOP;
        end else begin
            if (test_logic_reset_i) begin
                r_addr <= '0;
                r_data <= '0;
            end else if (w_start) begin
                r_addr <= r_dr[DrWidth-1 -: AddrWidth];
                r_op   <= w_dr_op;
                if (w_dr_op == DTM_WRITE) r_data <= r_dr[DataWidth+1:2];
            end
            if ((r_state == WaitRead) && dmi_resp_valid_i) r_data <= dmi_resp_data_i;
        end
    end

    // Sticky: only written from zero, and an explicit clear beats any new error.
    always_ff @(posedge tck_i) begin
        if (!trst_ni) begin
            r_error <= 2'd0;
        end else if (dmi_reset_i || test_logic_reset_i) begin
            r_error <= 2'd0;
        end else if (r_error == 2'd0) begin
            if (w_busy_hit) begin
                r_error <= 2'd3;
            end else if (w_resp_fail) begin
                r_error <= 2'd2;
            end
        end
    end

    assign dmi_tdo_o      = r_dr[0];
    assign dmi_error_o    = r_error;
    assign dmi_req_addr_o = r_addr;
    assign dmi_req_op_o   = r_op;
    assign dmi_req_data_o = r_data;

endmodule

// File: tb/tb_dmi_jtag_access_ctrl.sv
// Directed bench for dmi_jtag_access_ctrl: scans DR vectors through the TAP
// strobes and checks DMI channel activity and sticky error behaviour.
module tb_dmi_jtag_access_ctrl;

    logic        tck = 1'b0;
    logic        trst_n;
    logic        dmi_access, capture_dr, shift_dr, update_dr, tlr, dmi_reset, tdi;
    logic        tdo;
    logic [1:0]  err;
    logic        req_valid, req_ready;
    logic [6:0]  req_addr;
    logic [1:0]  req_op;
    logic [31:0] req_data;
    logic        resp_valid, resp_ready;
    logic [31:0] resp_data;
    logic [1:0]  resp_resp;

    int checks = 0;
    int errors = 0;

    always #5 tck = ~tck;

    dmi_jtag_access_ctrl #(.AddrWidth(7), .DataWidth(32)) dut (
        .tck_i              (tck),
        .trst_ni            (trst_n),
        .dmi_access_i       (dmi_access),
        .capture_dr_i       (capture_dr),
        .shift_dr_i         (shift_dr),
        .update_dr_i        (update_dr),
        .test_logic_reset_i (tlr),
        .dmi_reset_i        (dmi_reset),
        .dmi_tdi_i          (tdi),
        .dmi_tdo_o          (tdo),
        .dmi_error_o        (err),
        .dmi_req_valid_o    (req_valid),
        .dmi_req_ready_i    (req_ready),
        .dmi_req_addr_o     (req_addr),
        .dmi_req_op_o       (req_op),
        .dmi_req_data_o     (req_data),
        .dmi_resp_valid_i   (resp_valid),
        .dmi_resp_ready_o   (resp_ready),
        .dmi_resp_data_i    (resp_data),
        .dmi_resp_resp_i    (resp_resp)
    );

    task automatic tick();
        @(posedge tck);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Capture, then shift val in while collecting the captured value from tdo.
    task automatic scan(input logic [40:0] val, output logic [40:0] out);
        capture_dr = 1'b1;
        tick();
        capture_dr = 1'b0;
        shift_dr   = 1'b1;
        for (int i = 0; i < 41; i++) begin
            tdi    = val[i];
            out[i] = tdo;
            tick();
        end
        shift_dr = 1'b0;
        tdi      = 1'b0;
    endtask

    task automatic update();
        update_dr = 1'b1;
        tick();
        update_dr = 1'b0;
    endtask

    task automatic accept_req();
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
    endtask

    task automatic respond(input logic [31:0] d, input logic [1:0] r);
        resp_valid = 1'b1;
        resp_data  = d;
        resp_resp  = r;
        tick();
        resp_valid = 1'b0;
        resp_data  = '0;
        resp_resp  = '0;
    endtask

    task automatic test_reset();
        trst_n = 1'b0;
        tick();
        tick();
        if (req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b expected 0", req_valid); end
        checks++;
        if (resp_ready !== 1'b0) begin errors++; $display("FAIL reset_resp_ready: got %b expected 0", resp_ready); end
        checks++;
        if (tdo !== 1'b0) begin errors++; $display("FAIL reset_tdo: got %b expected 0", tdo); end
        checks++;
        if (err !== 2'd0) begin errors++; $display("FAIL reset_error: got %0d expected 0", err); end
        checks++;
        if (req_addr !== 7'h0 || req_data !== 32'h0) begin
            errors++; $display("FAIL reset_req_fields: got addr %h data %h expected 0 0", req_addr, req_data);
        end
        checks++;
        trst_n = 1'b1;
        tick();
    endtask

    task automatic test_write();
        logic [40:0] o;
        scan({7'h10, 32'hDEADBEEF, 2'd2}, o);
        if (req_valid !== 1'b0) begin errors++; $display("FAIL write_no_early_valid: got %b expected 0", req_valid); end
        checks++;
        update();
        if ({req_valid, req_addr, req_op, req_data} !== {1'b1, 7'h10, 2'd2, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL write_req: got v%b a%h op%0d d%h expected v1 a10 op2 dDEADBEEF", req_valid, req_addr, req_op, req_data);
        end
        checks++;
        tick();
        if (req_valid !== 1'b1 || req_data !== 32'hDEADBEEF) begin
            errors++; $display("FAIL write_hold: got v%b d%h expected v1 dDEADBEEF", req_valid, req_data);
        end
        checks++;
        accept_req();
        if (req_valid !== 1'b0 || resp_ready !== 1'b1) begin
            errors++; $display("FAIL write_wait: got v%b rr%b expected v0 rr1", req_valid, resp_ready);
        end
        checks++;
        respond(32'h0, 2'd0);
        if (resp_ready !== 1'b0 || err !== 2'd0) begin
            errors++; $display("FAIL write_done: got rr%b err%0d expected rr0 err0", resp_ready, err);
        end
        checks++;
    endtask

    task automatic test_read();
        logic [40:0] o;
        scan({7'h11, 32'h0, 2'd1}, o);
        update();
        if (req_valid !== 1'b1 || req_op !== 2'd1 || req_addr !== 7'h11) begin
            errors++; $display("FAIL read_req: got v%b op%0d a%h expected v1 op1 a11", req_valid, req_op, req_addr);
        end
        checks++;
        accept_req();
        respond(32'h12345678, 2'd0);
        scan(41'h0, o);
        if (o !== {7'h11, 32'h12345678, 2'd0}) begin
            errors++; $display("FAIL read_capture: got %h expected %h", o, {7'h11, 32'h12345678, 2'd0});
        end
        checks++;
    endtask

    task automatic test_busy();
        logic [40:0] o;
        scan({7'h20, 32'hCAFEF00D, 2'd2}, o);
        update();
        scan({7'h21, 32'h11111111, 2'd2}, o);
        if (o !== {7'h20, 32'hCAFEF00D, 2'd3}) begin
            errors++; $display("FAIL busy_capture: got %h expected %h", o, {7'h20, 32'hCAFEF00D, 2'd3});
        end
        checks++;
        if (err !== 2'd3) begin errors++; $display("FAIL busy_error: got %0d expected 3", err); end
        checks++;
        update();
        if (req_addr !== 7'h20 || req_data !== 32'hCAFEF00D || req_valid !== 1'b1) begin
            errors++; $display("FAIL busy_update_ignored: got a%h d%h v%b expected a20 dCAFEF00D v1", req_addr, req_data, req_valid);
        end
        checks++;
        accept_req();
        respond(32'h0, 2'd0);
        tick();
        tick();
        tick();
        if (req_valid !== 1'b0 || err !== 2'd3) begin
            errors++; $display("FAIL busy_single_txn: got v%b err%0d expected v0 err3", req_valid, err);
        end
        checks++;
    endtask

    task automatic test_clear();
        logic [40:0] o;
        dmi_reset = 1'b1;
        tick();
        dmi_reset = 1'b0;
        if (err !== 2'd0) begin errors++; $display("FAIL clear_error: got %0d expected 0", err); end
        checks++;
        scan({7'h05, 32'h0, 2'd1}, o);
        update();
        if (req_valid !== 1'b1 || req_addr !== 7'h05) begin
            errors++; $display("FAIL clear_then_req: got v%b a%h expected v1 a05", req_valid, req_addr);
        end
        checks++;
        capture_dr = 1'b1;
        dmi_reset  = 1'b1;
        tick();
        capture_dr = 1'b0;
        dmi_reset  = 1'b0;
        if (err !== 2'd0) begin errors++; $display("FAIL clear_priority: got %0d expected 0", err); end
        checks++;
        accept_req();
        respond(32'h0, 2'd0);
    endtask

    task automatic test_failed();
        logic [40:0] o;
        scan({7'h06, 32'h0, 2'd1}, o);
        update();
        accept_req();
        respond(32'h55AA55AA, 2'd2);
        if (err !== 2'd2) begin errors++; $display("FAIL failed_error: got %0d expected 2", err); end
        checks++;
        scan({7'h07, 32'h0, 2'd1}, o);
        update();
        tick();
        if (req_valid !== 1'b0 || err !== 2'd2) begin
            errors++; $display("FAIL failed_blocks_req: got v%b err%0d expected v0 err2", req_valid, err);
        end
        checks++;
        dmi_reset = 1'b1;
        tick();
        dmi_reset = 1'b0;
    endtask

    task automatic test_trst();
        logic [40:0] o;
        scan({7'h33, 32'h01020304, 2'd2}, o);
        update();
        if (req_valid !== 1'b1) begin errors++; $display("FAIL trst_pre_valid: got %b expected 1", req_valid); end
        checks++;
        trst_n = 1'b0;
        tick();
        trst_n = 1'b1;
        if ({req_valid, resp_ready, tdo, err, req_addr, req_op, req_data} !== 45'h0) begin
            errors++;
            $display("FAIL trst_mid_write: got v%b rr%b tdo%b err%0d a%h op%0d d%h expected all 0",
                     req_valid, resp_ready, tdo, err, req_addr, req_op, req_data);
        end
        checks++;
        tick();
        if (req_valid !== 1'b0) begin errors++; $display("FAIL trst_idle: got %b expected 0", req_valid); end
        checks++;
    endtask

    task automatic test_tlr();
        logic [40:0] o;
        scan({7'h44, 32'h0, 2'd1}, o);
        update();
        accept_req();
        tlr = 1'b1;
        tick();
        if (resp_ready !== 1'b1 || req_addr !== 7'h0) begin
            errors++; $display("FAIL tlr_wait: got rr%b a%h expected rr1 a00", resp_ready, req_addr);
        end
        checks++;
        respond(32'hA5A5A5A5, 2'd0);
        tlr = 1'b0;
        if (resp_ready !== 1'b0 || req_data !== 32'hA5A5A5A5 || err !== 2'd0) begin
            errors++; $display("FAIL tlr_resp: got rr%b d%h err%0d expected rr0 dA5A5A5A5 err0", resp_ready, req_data, err);
        end
        checks++;
        chk("tlr_idle_after", {63'h0, req_valid}, 64'h0);
    endtask

    initial begin
        trst_n     = 1'b0;
        dmi_access = 1'b1;
        capture_dr = 1'b0;
        shift_dr   = 1'b0;
        update_dr  = 1'b0;
        tlr        = 1'b0;
        dmi_reset  = 1'b0;
        tdi        = 1'b0;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_data  = '0;
        resp_resp  = '0;
        test_reset();
        test_write();
        test_read();
        test_busy();
        test_clear();
        test_failed();
        test_trst();
        test_tlr();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
